pdm_decoder: RTL
================

PDM_DECODER -- requirements
Module: pdm_decoder

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 5, meaning window length 2**WIN_LOG2 samples.
REQ-002 SHALL have parameter LEVEL_W, default 5, meaning width of recovered level (equals WIN_LOG2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  decoder enable; low forces IDLE.
REQ-006 SHALL have port sample_en  input  1  qualifies pdm_in this cycle.
REQ-007 SHALL have port pdm_in  input  1  pulse-density-modulated bitstream.
REQ-008 SHALL have port resync  input  1  restarts the current window.
REQ-009 SHALL have port level  output  LEVEL_W  last recovered density level.
REQ-010 SHALL have port level_valid  output  1  one-cycle pulse when level updates.
REQ-011 SHALL have port level_changed  output  1  one-cycle pulse when new level differs from previous.

Function
REQ-012 SHALL implement states IDLE and ACCUM; IDLE->ACCUM when en=1; any state->IDLE when en=0.
REQ-013 SHALL, in ACCUM, on each cycle with sample_en=1, increment a WIN_LOG2-bit sample counter and add pdm_in to a (WIN_LOG2+1)-bit ones counter.
REQ-014 SHALL, on the sample that wraps the sample counter (2**WIN_LOG2-th), register the total ones count into level and assert level_valid on the following cycle.
REQ-015 SHALL saturate a full-window count of 2**WIN_LOG2 to level = all-ones (e.g. 32 -> 31).
REQ-016 SHALL clear the ones counter at window end, and count the wrapping sample into the completed window, not the next.
REQ-017 SHALL hold level and the counters unchanged on cycles with sample_en=0.
REQ-018 SHALL, on resync=1, clear both counters without updating level; resync takes priority over a coincident sample.
REQ-019 SHALL assert level_changed together with level_valid only when the new level differs from the prior level.
REQ-020 SHALL, on entry to IDLE, clear counters, retain level, and hold level_valid and level_changed low.

Reset
REQ-021 SHALL, on reset low (asynchronous), force state IDLE, counters 0, level 0, level_valid 0, level_changed 0.
REQ-022 SHALL discard a partial window when reset asserts mid-window; the first window after release starts at sample 0.

Configuration
REQ-023 SHALL, with PDM_DEC_MAVG_EN defined, add a 2**WIN_LOG2-bit history shift register and update level on every qualified sample as ones-in-last-window (add new bit, subtract bit leaving), pulsing level_valid each qualified sample once the history has filled.
REQ-024 SHALL, without PDM_DEC_MAVG_EN, implement only the block-window behaviour of REQ-013..REQ-016 and contain no history register.
REQ-025 SHALL clear the history register on reset, resync and IDLE entry when PDM_DEC_MAVG_EN is defined.

Structure
REQ-026 SHALL place the state enum (IDLE, ACCUM) and the default WIN_LOG2/LEVEL_W constants in the shared pdm_pkg package used by the PDM encoder.
REQ-027 SHALL contain one sub-module, pdm_ones_counter (sample counter plus ones accumulator with wrap flag); all other logic is in pdm_decoder.

Verification
REQ-028 SHALL cover: en=1, sample_en=1, 32 samples with 8 evenly spaced ones -> level=8, level_valid pulse on the cycle after the 32nd sample, level_changed=1.
REQ-029 SHALL cover: all-ones window -> level=31 (saturated); a following all-zeros window -> level=0, level_changed=1.
REQ-030 SHALL cover: two identical windows of 26 ones (0x1a) -> level=26 both times; level_changed=1 only on the first.
REQ-031 SHALL cover: sample_en toggled every other cycle with a 15-ones pattern -> level=15 after 64 clocks; no update before then.
REQ-032 SHALL cover: reset low at sample 10 and resync=1 at sample 20 in separate runs -> outputs cleared (reset) or level retained (resync); next level_valid exactly 32 qualified samples later.
REQ-033 SHALL cover: with PDM_DEC_MAVG_EN defined, a 4-ones-per-32 stream -> level_valid every sample after 32 fill samples, level steady at 4.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared PDM definitions: decoder states and default window sizing.
// Used by both the PDM encoder and the PDM decoder.
package pdm_pkg;

  localparam int WIN_LOG2_DEF = 5;
  localparam int LEVEL_W_DEF  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pdm_state_e;

endpackage

// File: rtl/pdm_ones_counter.sv
// Window sample counter plus ones accumulator for the PDM decoder.
// wrap_o marks the last sample of a window; total_o includes it.
module pdm_ones_counter
  import pdm_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              bit_i,
  output logic              wrap_o,
  output logic [WIN_LOG2:0] total_o
);

  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [WIN_LOG2:0]   ones_q, ones_d;

  // Count qualified samples; clear wins over a coincident sample.
  always_comb begin
    total_o = ones_q + (WIN_LOG2+1)'(bit_i);
    wrap_o  = inc_i && !clr_i && (&cnt_q);
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    if (clr_i) begin
      cnt_d  = '0;
      ones_d = '0;
    end else if (inc_i) begin
      cnt_d  = cnt_q + WIN_LOG2'(1);
      ones_d = wrap_o ? '0 : total_o;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      ones_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ones_q <= ones_d;
    end
  end

endmodule

// File: rtl/pdm_decoder.sv
// PDM decoder: recovers density level per 2**WIN_LOG2-sample window.
// Define PDM_DEC_MAVG_EN for a sliding-window (moving average) level.
module pdm_decoder
  import pdm_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int LEVEL_W  = LEVEL_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               sample_en,
  input  logic               pdm_in,
  input  logic               resync,
  output logic [LEVEL_W-1:0] level,
  output logic               level_valid,
  output logic               level_changed
);

  pdm_state_e          state_q, state_d;
  logic                accum, clr, inc, wrap, upd;
  logic [WIN_LOG2:0]   total, cnt_new;
  logic [LEVEL_W-1:0]  sat, level_q, level_d;
  logic                valid_q, valid_d;
  logic                chg_q, chg_d;

  // Next state: en alone steers IDLE/ACCUM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (en)  state_d = ACCUM;
      ACCUM: if (!en) state_d = IDLE;
    endcase
  end

  // Counters run only in ACCUM; IDLE and resync hold them clear.
  always_comb begin
    accum = (state_q == ACCUM) && en;
    clr   = !accum || resync;
    inc   = accum && sample_en;
  end

  pdm_ones_counter #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .inc_i   (inc),
    .bit_i   (pdm_in),
    .wrap_o  (wrap),
    .total_o (total)
  );

`ifdef PDM_DEC_MAVG_EN
  localparam int N = 2**WIN_LOG2;

  logic [N-1:0]      hist_q, hist_d;
  logic [WIN_LOG2:0] sum_q, sum_d;
  logic              fill_q, fill_d;

  // Sliding sum: add the new bit, drop the bit leaving the window.
  always_comb begin
    hist_d = hist_q;
    sum_d  = sum_q;
    fill_d = fill_q;
    if (clr) begin
      hist_d = '0;
      sum_d  = '0;
      fill_d = 1'b0;
    end else if (inc) begin
      hist_d = {hist_q[N-2:0], pdm_in};
      sum_d  = sum_q + (WIN_LOG2+1)'(pdm_in)
             - (WIN_LOG2+1)'(hist_q[N-1]);
      if (wrap) fill_d = 1'b1;
    end
    cnt_new = sum_d;
    upd     = inc && !resync && (fill_q || wrap);
  end

  // History and running-sum registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      sum_q  <= '0;
      fill_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      sum_q  <= sum_d;
      fill_q <= fill_d;
    end
  end
`else
  // Block window: level updates once per completed window.
  always_comb begin
    cnt_new = total;
    upd     = wrap;
  end
`endif

  // Saturate a full window (2**WIN_LOG2) to all-ones; flag changes.
  always_comb begin
    sat     = cnt_new[WIN_LOG2] ? '1
            : LEVEL_W'(cnt_new[WIN_LOG2-1:0]);
    level_d = level_q;
    valid_d = 1'b0;
    chg_d   = 1'b0;
    if (upd) begin
      level_d = sat;
      valid_d = 1'b1;
      chg_d   = (sat != level_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

  assign level         = level_q;
  assign level_valid   = valid_q;
  assign level_changed = chg_q;

endmodule
